// File: rtl/rom_fetch_unit_pkg.sv
// Shared constants and types for the ROM fetch front end.
package rom_fetch_unit_pkg;

  localparam int FETCH_ADDR_WIDTH = 8;
  localparam int FETCH_DATA_WIDTH = 8;
  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_VECTOR = 8'h00;

  // One prefetched instruction byte together with the ROM address it came from.
  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [FETCH_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : rom_fetch_unit_pkg

// File: rtl/rom_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, synchronous push/pop, flush has priority.
// The head entry is read combinationally; a push is visible from the next cycle.
module rom_fetch_unit_fetch_fifo
  import rom_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_entry,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [cnt_width(DEPTH)-1:0]  o_count,
  output fetch_entry_t                 o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  fetch_entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;

  // Pointer advance that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; flush empties the FIFO but keeps the storage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: storage is reset too, so the head reads as zero straight after reset;
      // without that requirement the data array would be left unreset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register updates from
      // pre-edge values regardless of statement order.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule : rom_fetch_unit_fetch_fifo

// File: rtl/rom_fetch_unit.sv
// ROM fetch front end: drives the synchronous program ROM, absorbs its one-cycle
// read latency, buffers bytes in a prefetch FIFO and hands them to the decoder
// over valid/ready. A jump flushes everything and redirects the fetch PC.
module rom_fetch_unit
  import rom_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = FETCH_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = FETCH_DATA_WIDTH,
  parameter int                    DEPTH        = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [DATA_WIDTH-1:0] INSTR_DATA,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic                  r_pending;

  logic [CNT_W-1:0]      w_count;
  fetch_entry_t          w_head;
  fetch_entry_t          w_push_entry;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CNT_W:0]        w_credit_used;
  logic [CNT_W:0]        w_credit_limit;

  // Credit rule: an issue is allowed only if every byte already buffered or in
  // flight, less the one leaving this cycle, still leaves a free FIFO slot.
  // Written as used < DEPTH + pop to avoid an unsigned underflow.
  assign INSTR_VALID    = (w_count != '0);
  assign w_pop          = INSTR_VALID & INSTR_READY;
  assign w_credit_used  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
  assign w_credit_limit = DEPTH_EXT + {{CNT_W{1'b0}}, w_pop};
  assign w_issue        = !JUMP && (w_credit_used < w_credit_limit);

  // The ROM byte for the address issued last cycle arrives now; a jump drops it.
  assign w_push         = r_pending & ~JUMP;
  assign w_push_entry   = '{addr: r_pend_addr, data: ROM_DATA};

  // Fetch PC and in-flight tracking; a jump overrides issue and drops the in-flight read.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_fetch_pc  <= RESET_VECTOR;
      r_pend_addr <= '0;
      r_pending   <= 1'b0;
    end else if (JUMP) begin
      r_fetch_pc  <= JUMP_ADDR;
      r_pending   <= 1'b0;
    end else if (w_issue) begin
      r_pending   <= 1'b1;
      r_pend_addr <= r_fetch_pc;
      r_fetch_pc  <= r_fetch_pc + ADDR_WIDTH'(1);
    end else begin
      r_pending   <= 1'b0;
    end
  end

  rom_fetch_unit_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk        (CLK),
    .i_rst_n      (RESETN),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (JUMP),
    .o_count      (w_count),
    .o_head       (w_head)
  );

  assign ROM_ADDR   = r_fetch_pc;
  assign INSTR_DATA = w_head.data;
  assign INSTR_ADDR = w_head.addr;

  // Buffered plus in-flight bytes never exceed the FIFO capacity.
  a_credit_bound : assert property (@(posedge CLK) disable iff (!RESETN)
    (32'(w_count) + 32'(r_pending)) <= DEPTH);

endmodule : rom_fetch_unit
